vec_dot_engine: RTL

- Parametrised successor to the serial vector MAC: computes the signed dot product of two C-element vectors using P multipliers per cycle.
- Adds a valid/ready handshake on input and output, chained accumulation across vectors, a runtime arithmetic right-shift, and a saturate-or-truncate output stage with an overflow flag.
- Sits between the vector register file and the processing-element writeback path.

---
 rtl/vec_dot_engine.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/vec_dot_engine.sv
// Signed dot product of two C-element vectors, P lanes per beat, N=ceil(C/P) beats.
// Valid/ready on both sides. Optional accumulation across vectors. Shift, then saturate or truncate.
module vec_dot_engine #(
  parameter int C     = 8,
  parameter int P     = 2,
  parameter int W_X   = 8,
  parameter int W_K   = 8,
  parameter int W_ACC = 32,
  parameter int W_SH  = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [C*W_X-1:0]     x,
  input  logic [C*W_K-1:0]     k,
  input  logic                 acc_en,
  input  logic [W_SH-1:0]      shift,
  input  logic                 sat_en,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [W_X-1:0]       y_out,
  output logic [W_ACC-1:0]     y_full,
  output logic                 ovf
);

  localparam int N  = (C + P - 1) / P;
  localparam int BW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = W_X + W_K;
  localparam logic signed [W_ACC-1:0] MAXV = W_ACC'((2 ** (W_X - 1)) - 1);
  localparam logic signed [W_ACC-1:0] MINV = W_ACC'(-(2 ** (W_X - 1)));

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [C*W_X-1:0]        x_q;
  logic [C*W_K-1:0]        k_q;
  logic [W_SH-1:0]         shift_q;
  logic                    sat_q;
  logic signed [W_ACC-1:0] acc;
  logic signed [W_ACC-1:0] acc_nxt;
  logic signed [W_ACC-1:0] lane_sum;
  logic signed [W_ACC-1:0] shifted;
  logic signed [PW-1:0]    xe;
  logic signed [PW-1:0]    ke;
  logic signed [PW-1:0]    prod;
  logic [BW-1:0]           beat;
  logic                    last_beat;
  logic                    accept;
  logic                    fits;
  logic [W_X-1:0]          y_nxt;

  logic signed [W_X-1:0] xa [N][P];
  logic signed [W_K-1:0] ka [N][P];

  // Lanes past element C-1 read as zero so the final partial beat needs no special case.
  for (genvar b = 0; b < N; b++) begin : g_beat
    for (genvar j = 0; j < P; j++) begin : g_lane
      localparam int I = b * P + j;
      if (I < C) begin : g_elem
        assign xa[b][j] = x_q[I*W_X +: W_X];
        assign ka[b][j] = k_q[I*W_K +: W_K];
      end else begin : g_pad
        assign xa[b][j] = '0;
        assign ka[b][j] = '0;
      end
    end
  end

  assign accept    = in_valid && in_ready;
  assign last_beat = (beat == BW'(N - 1));

  always_comb begin
    lane_sum = '0;
    xe       = '0;
    ke       = '0;
    prod     = '0;
    for (int j = 0; j < P; j++) begin
      xe       = PW'(xa[beat][j]);
      ke       = PW'(ka[beat][j]);
      prod     = xe * ke;
      lane_sum = lane_sum + W_ACC'(prod);
    end
  end

  assign acc_nxt = acc + lane_sum;
  assign shifted = acc_nxt >>> shift_q;
  assign fits    = (shifted >= MINV) && (shifted <= MAXV);

  always_comb begin
    y_nxt = shifted[W_X-1:0];
    if (!fits && sat_q) begin
      y_nxt = shifted[W_ACC-1] ? MINV[W_X-1:0] : MAXV[W_X-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)    state_nxt = RUN;
      RUN:     if (last_beat) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // The accumulator survives DONE so a following acc_en=1 vector chains onto it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q     <= '0;
      k_q     <= '0;
      shift_q <= '0;
      sat_q   <= 1'b0;
      acc     <= '0;
      beat    <= '0;
      y_out   <= '0;
      y_full  <= '0;
      ovf     <= 1'b0;
    end else if (accept) begin
      x_q     <= x;
      k_q     <= k;
      shift_q <= shift;
      sat_q   <= sat_en;
      acc     <= acc_en ? acc : '0;
      beat    <= '0;
    end else if (state == RUN) begin
      acc  <= acc_nxt;
      beat <= last_beat ? '0 : beat + BW'(1);
      if (last_beat) begin
        y_full <= acc_nxt;
        y_out  <= y_nxt;
        ovf    <= !fits;
      end
    end
  end

endmodule
